// File: rtl/bus_host_master_if.sv
// Command/response and M0 bus signal bundle for bus_host_master.
//   master modport: the bus_host_master view (accepts commands, drives the bus).
//   slave modport : the host/bus side view (pushes commands, grants, returns read data).
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : command push port
//   rsp_valid/rsp_data/rsp_err                   : one-cycle response pulse
//   busy                                         : engine or FIFO active
//   M_req/M_wr/M_address/M_dout                  : registered bus request outputs
//   M_grant/M_din                                : arbiter grant and read data
//   interrupt                                    : level interrupt input
interface bus_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic        M_grant;
  logic [31:0] M_din;
  logic        interrupt;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, M_grant, M_din, interrupt,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, M_req, M_wr, M_address, M_dout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, M_grant, M_din, interrupt,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, M_req, M_wr, M_address, M_dout
  );
endinterface

// File: rtl/bus_host_master.sv
// Command-driven M0 bus master. Buffers write / read / wait-for-interrupt commands in a
// small FIFO and executes them one at a time over the request/grant bus, returning one
// response per command in command order.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus_io  : bus_host_master_if.master (command, response, bus and interrupt signals)
// Parameters:
//   CMD_DEPTH   : command FIFO entries (power of two, >= 2)
//   IRQ_TIMEOUT : cycles spent waiting for the interrupt before aborting with an error
module bus_host_master #(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned IRQ_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset_n,
  bus_host_master_if.master bus_io
);

  localparam int unsigned PtrW = $clog2(CMD_DEPTH);
  localparam int unsigned CntW = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(CMD_DEPTH);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [CntW-1:0] WaitLast = CntW'(IRQ_TIMEOUT - 1);
  localparam logic [CntW-1:0] WaitOne  = CntW'(1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StRdata   = 3'd2;
  localparam logic [2:0] StWaitIrq = 3'd3;
  localparam logic [2:0] StResp    = 3'd4;

  localparam logic [1:0] OpWrite   = 2'b00;
  localparam logic [1:0] OpRead    = 2'b01;
  localparam logic [1:0] OpWaitIrq = 2'b10;

  // Command FIFO: entry = {op, addr, data}
  logic [41:0]     fifo_mem [CMD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            full, push, pop;
  logic [41:0]     head;
  logic [1:0]      head_op;
  logic [7:0]      head_addr;
  logic [31:0]     head_data;

  logic [2:0]      state_q, state_d;
  logic            m_req_q, m_req_d;
  logic            m_wr_q, m_wr_d;
  logic [7:0]      m_address_q, m_address_d;
  logic [31:0]     m_dout_q, m_dout_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  // Pending result, published to rsp_* on the way out of RESP
  logic [31:0]     result_data_q, result_data_d;
  logic            result_err_q, result_err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  assign full      = (count_q == DepthCnt);
  assign push      = bus_io.cmd_valid & ~full;
  assign pop       = (state_q == StIdle) & (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];
  assign head_op   = head[41:40];
  assign head_addr = head[39:32];
  assign head_data = head[31:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus_io.cmd_op, bus_io.cmd_addr, bus_io.cmd_data};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    state_d       = state_q;
    m_req_d       = m_req_q;
    m_wr_d        = m_wr_q;
    m_address_d   = m_address_q;
    m_dout_d      = m_dout_q;
    wait_cnt_d    = wait_cnt_q;
    result_data_d = result_data_q;
    result_err_d  = result_err_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          case (head_op)
            OpWrite, OpRead: begin
              m_req_d       = 1'b1;
              m_wr_d        = (head_op == OpWrite);
              m_address_d   = head_addr;
              m_dout_d      = head_data;
              result_data_d = head_data;
              result_err_d  = 1'b0;
              state_d       = StReq;
            end
            OpWaitIrq: begin
              wait_cnt_d = '0;
              state_d    = StWaitIrq;
            end
            default: begin
              result_data_d = '0;
              result_err_d  = 1'b1;
              state_d       = StResp;
            end
          endcase
        end
      end
      StReq: begin
        // The granted cycle is the transfer cycle; drop the request at its closing edge.
        if (bus_io.M_grant) begin
          m_req_d = 1'b0;
          m_wr_d  = 1'b0;
          state_d = m_wr_q ? StResp : StRdata;
        end
      end
      StRdata: begin
        result_data_d = bus_io.M_din;
        result_err_d  = 1'b0;
        state_d       = StResp;
      end
      StWaitIrq: begin
        if (bus_io.interrupt) begin
          result_data_d = 32'(wait_cnt_q);
          result_err_d  = 1'b0;
          state_d       = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          // This cycle's increment would reach the limit.
          result_data_d = 32'(IRQ_TIMEOUT);
          result_err_d  = 1'b1;
          state_d       = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitOne;
        end
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_data_q;
        rsp_err_d   = result_err_q;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      m_req_q       <= 1'b0;
      m_wr_q        <= 1'b0;
      m_address_q   <= '0;
      m_dout_q      <= '0;
      wait_cnt_q    <= '0;
      result_data_q <= '0;
      result_err_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      m_req_q       <= m_req_d;
      m_wr_q        <= m_wr_d;
      m_address_q   <= m_address_d;
      m_dout_q      <= m_dout_d;
      wait_cnt_q    <= wait_cnt_d;
      result_data_q <= result_data_d;
      result_err_q  <= result_err_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus_io.cmd_ready = ~full;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_data  = rsp_data_q;
  assign bus_io.rsp_err   = rsp_err_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.M_req     = m_req_q;
  assign bus_io.M_wr      = m_wr_q;
  assign bus_io.M_address = m_address_q;
  assign bus_io.M_dout    = m_dout_q;

endmodule

// File: tb/tb_bus_host_master.sv
// Self-checking bench for bus_host_master: scoreboard of expected responses plus
// per-scenario tasks checking bus timing, FIFO full/wrap, wait-irq and reset behaviour.
module tb_bus_host_master;

  localparam logic [1:0] OpWr   = 2'b00;
  localparam logic [1:0] OpRd   = 2'b01;
  localparam logic [1:0] OpWait = 2'b10;
  localparam logic [1:0] OpRsv  = 2'b11;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_host_master_if bus_if ();

  bus_host_master #(
    .CMD_DEPTH  (4),
    .IRQ_TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  int          rsp_cnt  = 0;
  logic [32:0] exp_q [$];  // {err, data}

  function automatic logic [31:0] rd_val(input logic [7:0] a);
    return (a == 8'h20) ? 32'h0000_0078 : {8'h5A, a, 8'hC3, a};
  endfunction

  // Bus slave: read data is valid only in the cycle after the transfer cycle.
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = '0;
  always @(negedge clk) begin
    rd_pend <= bus_if.M_req && bus_if.M_grant && !bus_if.M_wr;
    rd_addr <= bus_if.M_address;
  end
  always @(posedge clk) begin
    #1;
    bus_if.M_din = rd_pend ? rd_val(rd_addr) : 32'hDEAD_BEEF;
  end

  // Response scoreboard and request-gap monitor
  int   low_run  = 0;
  bit   seen_req = 1'b0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    logic [32:0] want;
    if (reset_n === 1'b1) begin
      if (bus_if.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got err=%0d data=%h, required no response",
                   bus_if.rsp_err, bus_if.rsp_data);
        end else begin
          want = exp_q.pop_front();
          if ({bus_if.rsp_err, bus_if.rsp_data} !== want) begin
            failures++;
            $display("FAIL rsp_order: got err=%0d data=%h, required err=%0d data=%h",
                     bus_if.rsp_err, bus_if.rsp_data, want[32], want[31:0]);
          end
        end
        rsp_cnt++;
      end
      if (bus_if.M_req && !prev_req && seen_req) begin
        checks++;
        if (low_run < 2) begin
          failures++;
          $display("FAIL req_gap: got %0d low cycles, required >= 2", low_run);
        end
      end
      if (bus_if.M_req) begin
        seen_req = 1'b1;
        low_run  = 0;
      end else begin
        low_run++;
      end
      prev_req = bus_if.M_req;
    end else begin
      seen_req = 1'b0;
      prev_req = 1'b0;
      low_run  = 0;
    end
  end

  // Drives one command for one cycle starting at posedge+1; returns at posedge+1.
  task automatic push_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data,
                          input logic [32:0] exp_rsp, input bit exp_acc, output bit acc);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_data  = data;
    @(negedge clk);
    acc = bus_if.cmd_ready;
    if (exp_acc) exp_q.push_back(exp_rsp);
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (rsp_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bit acc, ok;
    int req_at = 0, rsp_at = 0, req_cyc = 0;
    reset_n          = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = OpWr;
    bus_if.cmd_addr  = 8'h77;
    bus_if.cmd_data  = 32'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.M_req !== 1'b0 || bus_if.M_wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_wr: got %b%b, required 00", bus_if.M_req, bus_if.M_wr);
    end
    checks++;
    if (bus_if.M_address !== 8'h0 || bus_if.M_dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus_out: got addr=%h dout=%h, required 0 0",
               bus_if.M_address, bus_if.M_dout);
    end
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data} !== 34'h0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h, required 0 0 0",
               bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_data);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b, required 0", bus_if.busy);
    end
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b, required 1", bus_if.cmd_ready);
    end
    bus_if.cmd_valid = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus_if.M_grant = 1'b1;
    push_cmd(OpWr, 8'h01, 32'h5, {1'b0, 32'h5}, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL wr_accept: got %b, required 1", acc);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus_if.M_req === 1'b1 && req_at == 0) begin
        req_at = i;
        checks++;
        if (bus_if.M_wr !== 1'b1 || bus_if.M_address !== 8'h01 || bus_if.M_dout !== 32'h5) begin
          failures++;
          $display("FAIL wr_bus_out: got wr=%b addr=%h dout=%h, required 1 01 00000005",
                   bus_if.M_wr, bus_if.M_address, bus_if.M_dout);
        end
      end
      if (bus_if.rsp_valid === 1'b1 && rsp_at == 0) rsp_at = i;
      if (bus_if.M_req === 1'b1) req_cyc++;
    end
    checks++;
    if (req_at != 2) begin
      failures++;
      $display("FAIL wr_req_latency: got %0d, required 2", req_at);
    end
    checks++;
    if (rsp_at != 4) begin
      failures++;
      $display("FAIL wr_rsp_latency: got %0d, required 4", rsp_at);
    end
    checks++;
    if (req_cyc != 1) begin
      failures++;
      $display("FAIL wr_req_cycles: got %0d, required 1", req_cyc);
    end
    wait_rsp(1, 4, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wr_rsp_done: got rsp=%0d pending=%0d, required 1 0", rsp_cnt, exp_q.size());
    end
  endtask

  task automatic test_read_delayed();
    bit acc, ok, found;
    int hi;
    int base = rsp_cnt;
    bus_if.M_grant = 1'b0;
    push_cmd(OpRd, 8'h20, 32'h0, {1'b0, 32'h78}, 1'b1, acc);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus_if.M_req === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rd_req_seen: got 0, required 1");
    end
    checks++;
    if (bus_if.M_wr !== 1'b0 || bus_if.M_address !== 8'h20) begin
      failures++;
      $display("FAIL rd_bus_out: got wr=%b addr=%h, required 0 20", bus_if.M_wr, bus_if.M_address);
    end
    hi = 1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      bus_if.M_grant = (i == 2);
      @(negedge clk);
      if (bus_if.M_req === 1'b1) hi++;
    end
    bus_if.M_grant = 1'b0;
    checks++;
    if (hi != 3) begin
      failures++;
      $display("FAIL rd_req_hold: got %0d cycles, required 3", hi);
    end
    wait_rsp(base + 1, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rd_rsp_timeout: got %0d responses, required %0d", rsp_cnt - base, 1);
    end
  endtask

  task automatic test_fifo_full_wrap();
    bit acc, exp_acc, ok;
    int base = rsp_cnt;
    logic [7:0] a;
    bus_if.M_grant = 1'b0;
    // First command is popped into the engine, which then stalls; the next four fill the FIFO.
    for (int i = 0; i < 7; i++) begin
      exp_acc = (i < 5);
      push_cmd(OpWr, 8'(8'h40 + i), 32'(256 + i), {1'b0, 32'(256 + i)}, exp_acc, acc);
      checks++;
      if (acc !== exp_acc) begin
        failures++;
        $display("FAIL full_accept[%0d]: got %b, required %b", i, acc, exp_acc);
      end
    end
    @(negedge clk);
    checks++;
    if (bus_if.cmd_ready !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.M_req !== 1'b1) begin
      failures++;
      $display("FAIL full_state: got ready=%b busy=%b req=%b, required 0 1 1",
               bus_if.cmd_ready, bus_if.busy, bus_if.M_req);
    end
    @(posedge clk);
    #1;
    bus_if.M_grant = 1'b1;
    wait_rsp(base + 5, 80, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain: got %0d responses, required 5", rsp_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      a = 8'(8'h50 + i);
      if (i % 2 == 0) push_cmd(OpRd, a, 32'h0, {1'b0, rd_val(a)}, 1'b1, acc);
      else push_cmd(OpWr, a, 32'(32'hA00 + i), {1'b0, 32'(32'hA00 + i)}, 1'b1, acc);
      checks++;
      if (acc !== 1'b1) begin
        failures++;
        $display("FAIL wrap_accept[%0d]: got %b, required 1", i, acc);
      end
    end
    wait_rsp(base + 9, 80, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: got %0d responses, required 9", rsp_cnt - base);
    end
  endtask

  task automatic test_wait_irq();
    bit acc, ok;
    int lat = 0;
    int base = rsp_cnt;
    bus_if.interrupt = 1'b0;
    push_cmd(OpWait, 8'h0, 32'h0, {1'b0, 32'd10}, 1'b1, acc);
    repeat (11) @(posedge clk);
    #1 bus_if.interrupt = 1'b1;
    wait_rsp(base + 1, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL irq_rsp_timeout: got %0d responses, required 1", rsp_cnt - base);
    end
    // Interrupt already high on entry
    push_cmd(OpWait, 8'h0, 32'h0, {1'b0, 32'd0}, 1'b1, acc);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid === 1'b1) lat = i;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL irq_high_latency: got %0d, required 4", lat);
    end
    @(posedge clk);
    #1 bus_if.interrupt = 1'b0;
    push_cmd(OpWait, 8'h0, 32'h0, {1'b1, 32'd16}, 1'b1, acc);
    wait_rsp(base + 3, 40, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL irq_timeout_rsp: got %0d responses, required 3", rsp_cnt - base);
    end
  endtask

  task automatic test_reserved();
    bit acc, ok, req_seen, rsp_seen;
    int base = rsp_cnt;
    bus_if.M_grant = 1'b1;
    push_cmd(OpRsv, 8'h11, 32'hFFFF_FFFF, {1'b1, 32'h0}, 1'b1, acc);
    push_cmd(OpWr, 8'h33, 32'hCAFE, {1'b0, 32'hCAFE}, 1'b1, acc);
    req_seen = 1'b0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 10 && !rsp_seen; i++) begin
      @(negedge clk);
      if (bus_if.M_req === 1'b1) req_seen = 1'b1;
      if (bus_if.rsp_valid === 1'b1) rsp_seen = 1'b1;
    end
    checks++;
    if (req_seen || !rsp_seen) begin
      failures++;
      $display("FAIL rsv_no_bus: got req=%b rsp=%b, required 0 1", req_seen, rsp_seen);
    end
    wait_rsp(base + 2, 20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rsv_next_write: got %0d responses, required 2", rsp_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, found, req_seen;
    int base;
    bus_if.M_grant = 1'b0;
    push_cmd(OpWr, 8'h60, 32'h1, {1'b0, 32'h1}, 1'b1, acc);
    push_cmd(OpWr, 8'h61, 32'h2, {1'b0, 32'h2}, 1'b1, acc);
    push_cmd(OpRd, 8'h62, 32'h0, {1'b0, rd_val(8'h62)}, 1'b1, acc);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus_if.M_req === 1'b1) found = 1'b1;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!found || bus_if.M_req !== 1'b0 || bus_if.M_wr !== 1'b0) begin
      failures++;
      $display("FAIL midreset_req: got seen=%b req=%b wr=%b, required 1 0 0",
               found, bus_if.M_req, bus_if.M_wr);
    end
    exp_q.delete();
    base = rsp_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    bus_if.M_grant = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.M_req === 1'b1) req_seen = 1'b1;
    end
    checks++;
    if (req_seen || rsp_cnt != base) begin
      failures++;
      $display("FAIL midreset_flush: got req=%b rsps=%0d, required 0 0", req_seen, rsp_cnt - base);
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_empty: got busy=%b ready=%b, required 0 1",
               bus_if.busy, bus_if.cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_addr  = 8'h0;
    bus_if.cmd_data  = 32'h0;
    bus_if.M_grant   = 1'b0;
    bus_if.interrupt = 1'b0;
    test_reset();
    test_read_delayed();
    test_fifo_full_wrap();
    test_wait_irq();
    test_reserved();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
